// File: rtl/proc_core.sv
// proc_core: minimal 8-bit multi-cycle processor core.
//
// Holds a 256x16 instruction store, a program counter, an instruction
// register, a 4x8 register file and an 8-function ALU. Each instruction
// takes two cycles: FETCH then EXEC.
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   imem_we    - instruction-store write enable (IDLE/HALT only)
//   imem_waddr - instruction-store write address
//   imem_wdata - instruction word to write
//   start      - begin execution at pc 0 (IDLE/HALT only)
//   dbg_addr   - register-file debug read index
//   dbg_data   - combinational contents of R[dbg_addr]
//   pc         - current program counter
//   ir         - current instruction register
//   halted     - high while in HALT

// alu: combinational 8-bit ALU, results modulo 256, no flags.
//   op_i - function select, a_i/b_i - operands, y_o - result
module alu (
  input  logic [2:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);
  always_comb begin
    y_o = '0;
    case (op_i)
      3'b000:  y_o = a_i + b_i;
      3'b001:  y_o = a_i - b_i;
      3'b010:  y_o = a_i & b_i;
      3'b011:  y_o = a_i | b_i;
      3'b100:  y_o = a_i ^ b_i;
      3'b101:  y_o = ~a_i;
      3'b110:  y_o = {a_i[6:0], 1'b0};
      default: y_o = {1'b0, a_i[7:1]};
    endcase
  end
endmodule

// registers: four 8-bit registers, one synchronous write port, two
// combinational operand read ports and a combinational debug port.
module registers (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [1:0] raddr_a_i,
  input  logic [1:0] raddr_b_i,
  input  logic [1:0] raddr_dbg_i,
  output logic [7:0] rdata_a_o,
  output logic [7:0] rdata_b_o,
  output logic [7:0] rdata_dbg_o
);
  logic [7:0] rf_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = rf_q[raddr_a_i];
  assign rdata_b_o   = rf_q[raddr_b_i];
  assign rdata_dbg_o = rf_q[raddr_dbg_i];
endmodule

// inst_reg: 16-bit instruction register loaded while load_i is high.
module inst_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);
  logic [15:0] ir_q;

  always_ff @(posedge clk) begin
    if (rst)         ir_q <= '0;
    else if (load_i) ir_q <= d_i;
  end

  assign q_o = ir_q;
endmodule

// Sequencer states:
//   state   | meaning
//   S_IDLE  | after reset; program may be loaded, waiting for start
//   S_FETCH | ir <- imem[pc]
//   S_EXEC  | decode ir, write register file, update pc
//   S_HALT  | HLT executed; program may be reloaded, start re-runs
module proc_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_we,
  input  logic [7:0]  imem_waddr,
  input  logic [15:0] imem_wdata,
  input  logic        start,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [7:0]  pc,
  output logic [15:0] ir,
  output logic        halted
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_HLT  = 4'b1100;
  localparam logic [3:0] OP_DJNZ = 4'b1110;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] imem_q [256];
  logic [15:0] ir_w;
  logic        imem_wr_en;

  logic [3:0]  opcode;
  logic [1:0]  fld_d, fld_s, fld_t;
  logic [7:0]  fld_imm;

  logic [2:0]  alu_op;
  logic        a_from_s;
  logic        b_is_one;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic [7:0]  rd_a, rd_b;
  logic        rf_we;
  logic [7:0]  rf_wdata;

  // The store is not reset; loads are only accepted while the core is parked.
  assign imem_wr_en = imem_we && !rst && ((state_q == S_IDLE) || (state_q == S_HALT));

  always_ff @(posedge clk) begin
    if (imem_wr_en) imem_q[imem_waddr] <= imem_wdata;
  end

  inst_reg u_inst_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == S_FETCH),
    .d_i    (imem_q[pc_q]),
    .q_o    (ir_w)
  );

  assign opcode  = ir_w[15:12];
  assign fld_d   = ir_w[9:8];
  assign fld_s   = ir_w[5:4];
  assign fld_t   = ir_w[1:0];
  assign fld_imm = ir_w[7:0];

  // Operand/ALU control depends on the opcode only, kept apart from the
  // next-state logic that consumes the ALU result.
  always_comb begin
    alu_op   = 3'b000;
    a_from_s = 1'b0;
    b_is_one = 1'b0;
    case (opcode)
      OP_ADD:  a_from_s = 1'b1;
      OP_SUB:  begin a_from_s = 1'b1; alu_op = 3'b001; end
      OP_INC:  b_is_one = 1'b1;
      OP_DEC,
      OP_DJNZ: begin b_is_one = 1'b1; alu_op = 3'b001; end
      default: ;
    endcase
  end

  registers u_registers (
    .clk         (clk),
    .rst         (rst),
    .we_i        (rf_we),
    .waddr_i     (fld_d),
    .wdata_i     (rf_wdata),
    .raddr_a_i   (a_from_s ? fld_s : fld_d),
    .raddr_b_i   (fld_t),
    .raddr_dbg_i (dbg_addr),
    .rdata_a_o   (rd_a),
    .rdata_b_o   (rd_b),
    .rdata_dbg_o (dbg_data)
  );

  assign alu_a = rd_a;
  assign alu_b = b_is_one ? 8'd1 : rd_b;

  alu u_alu (
    .op_i (alu_op),
    .a_i  (alu_a),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rf_we    = 1'b0;
    rf_wdata = alu_y;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 8'd1;
        case (opcode)
          OP_LOAD: begin rf_we = 1'b1; rf_wdata = fld_imm; end
          OP_ADD, OP_SUB, OP_INC, OP_DEC: rf_we = 1'b1;
          OP_JMP:  pc_d = fld_imm;
          OP_DJNZ: begin
            rf_we = 1'b1;
            if (alu_y != 8'd0) pc_d = fld_imm;
          end
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign ir     = ir_w;
  assign halted = (state_q == S_HALT);
endmodule

// File: tb/tb_proc_core.sv
// Directed testbench for proc_core: loads small programs, runs them and
// checks registers, pc, ir, halted and cycle counts against hand-computed
// values.
module tb_proc_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        start;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_core dut (
    .clk        (clk),
    .rst        (rst),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .start      (start),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .pc         (pc),
    .ir         (ir),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, {8'h00, dbg_data}, {8'h00, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(posedge clk); #1;
    imem_we = 1'b0;
  endtask

  // Pulses start (optionally with a simultaneous store write), checks the
  // first fetched word, then counts cycles until halted (bounded).
  task automatic run(input string tag, input logic [15:0] first_ir, input int exp_cycles,
                     input logic do_wr, input logic [7:0] a, input logic [15:0] d);
    int n;
    start = 1'b1;
    imem_we = do_wr; imem_waddr = a; imem_wdata = d;
    @(posedge clk); #1;
    start = 1'b0; imem_we = 1'b0;
    chk({tag, "_started"}, {15'd0, halted}, 16'd0);
    @(posedge clk); #1;
    n = 1;
    chk({tag, "_first_ir"}, ir, first_ir);
    chk({tag, "_first_pc"}, {8'h00, pc}, 16'h0000);
    while (!halted && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_cycles"}, n[15:0], exp_cycles[15:0]);
  endtask

  initial begin
    rst = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    start = 1'b0; dbg_addr = '0;

    // Reset state
    do_reset();
    chk("rst_pc", {8'h00, pc}, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    for (int i = 0; i < 4; i++) chk_reg("rst_reg", i[1:0], 8'h00);

    // LOAD/ADD
    wr(8'd0, 16'h8105); wr(8'd1, 16'h8203); wr(8'd2, 16'h0012); wr(8'd3, 16'hC000);
    run("addprog", 16'h8105, 8, 1'b0, 8'd0, 16'h0);
    chk("add_halted", {15'd0, halted}, 16'd1);
    chk_reg("add_r0", 2'd0, 8'd8);
    chk_reg("add_r1", 2'd1, 8'd5);
    chk_reg("add_r2", 2'd2, 8'd3);
    chk("add_pc", {8'h00, pc}, 16'h0003);
    chk("add_ir", ir, 16'hC000);

    // SUB wrap and DEC from zero
    do_reset();
    wr(8'd0, 16'h8103); wr(8'd1, 16'h8205); wr(8'd2, 16'h1312);
    wr(8'd3, 16'hB000); wr(8'd4, 16'hC000);
    run("subprog", 16'h8103, 10, 1'b0, 8'd0, 16'h0);
    chk_reg("sub_r3", 2'd3, 8'd254);
    chk_reg("dec_r0", 2'd0, 8'd255);
    chk("sub_pc", {8'h00, pc}, 16'h0004);

    // INC wrap
    do_reset();
    wr(8'd0, 16'h81FF); wr(8'd1, 16'hA100); wr(8'd2, 16'hC000);
    run("incprog", 16'h81FF, 6, 1'b0, 8'd0, 16'h0);
    chk_reg("inc_r1", 2'd1, 8'd0);
    chk("inc_pc", {8'h00, pc}, 16'h0002);

    // Write word 0 together with start from HALT; registers kept (R1 0 -> 1)
    run("wrstart", 16'h8207, 6, 1'b1, 8'd0, 16'h8207);
    chk_reg("wrstart_r2", 2'd2, 8'd7);
    chk_reg("wrstart_r1", 2'd1, 8'd1);

    // JMP skips words 1-4
    do_reset();
    wr(8'd0, 16'hF005);
    for (int i = 1; i < 5; i++) wr(i[7:0], 16'h8009);
    wr(8'd5, 16'hC000);
    run("jmpprog", 16'hF005, 4, 1'b0, 8'd0, 16'h0);
    chk_reg("jmp_r0", 2'd0, 8'd0);
    chk("jmp_pc", {8'h00, pc}, 16'h0005);

    // DJNZ loop
    do_reset();
    wr(8'd0, 16'h8003); wr(8'd1, 16'h8100); wr(8'd2, 16'hA100);
    wr(8'd3, 16'hE002); wr(8'd4, 16'hC000);
    run("djnz", 16'h8003, 18, 1'b0, 8'd0, 16'h0);
    chk("djnz_halted", {15'd0, halted}, 16'd1);
    chk_reg("djnz_r1", 2'd1, 8'd3);
    chk_reg("djnz_r0", 2'd0, 8'd0);
    chk("djnz_pc", {8'h00, pc}, 16'h0004);

    // Restart from HALT re-runs the program
    run("djnz_rerun", 16'h8003, 18, 1'b0, 8'd0, 16'h0);
    chk_reg("rerun_r1", 2'd1, 8'd3);

    // Mid-loop: store writes ignored, then reset
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    imem_we = 1'b1; imem_waddr = 8'd4; imem_wdata = 16'hF000;
    @(posedge clk); #1;
    imem_waddr = 8'd0;
    @(posedge clk); #1;
    imem_we = 1'b0;
    chk("mid_running", {15'd0, halted}, 16'd0);
    chk_reg("mid_r1_nonzero", 2'd1, 8'd1);
    do_reset();
    chk("mrst_pc", {8'h00, pc}, 16'h0000);
    chk("mrst_ir", ir, 16'h0000);
    chk("mrst_halted", {15'd0, halted}, 16'd0);
    for (int i = 0; i < 4; i++) chk_reg("mrst_reg", i[1:0], 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_pc", {8'h00, pc}, 16'h0000);
    chk("idle_ir", ir, 16'h0000);
    chk("idle_halted", {15'd0, halted}, 16'd0);

    run("after_rst", 16'h8003, 18, 1'b0, 8'd0, 16'h0);
    chk_reg("after_r1", 2'd1, 8'd3);
    chk_reg("after_r0", 2'd0, 8'd0);
    chk("after_pc", {8'h00, pc}, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/proc_core.md
# proc_core

Minimal 8-bit multi-cycle processor core: a 256×16 instruction store, a program counter and instruction register, a four-entry 8-bit register file and an eight-function 8-bit ALU. It sits under a loader or host that writes a program, pulses `start`, and watches `halted`. It is the top of the small-processor datapath; `alu`, `registers` and `inst_reg` are its internal sub-blocks.

## Interface
- No parameters. Widths are fixed: data 8, instruction 16, PC 8, register index 2.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_we` in 1: instruction-store write enable. Honoured only in IDLE or HALT; ignored otherwise.
- `imem_waddr` in 8: instruction-store write address.
- `imem_wdata` in 16: instruction word to write.
- `start` in 1: in IDLE or HALT, begins execution at PC 0. Ignored in other states.
- `dbg_addr` in 2: register-file debug read index.
- `dbg_data` out 8: combinational contents of R[`dbg_addr`].
- `pc` out 8: current program counter.
- `ir` out 16: current instruction register.
- `halted` out 1: high while in HALT.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- **IDLE**
  - `start` → FETCH with `pc`=0.
- **FETCH**
  - `ir` ← imem[`pc`].
  - → EXEC.
- **EXEC**
  - Decodes `ir[15:12]`, performs the operation, updates the register file and `pc`.
  - → FETCH, or → HALT for HLT.
- **HALT**
  - `halted`=1.
  - `start` → FETCH with `pc`=0. Registers are kept.
- Field names: d=`ir[9:8]`, s=`ir[5:4]`, t=`ir[1:0]`, imm/addr=`ir[7:0]`. All other bits are don't-care.
- Opcodes:
  - 1000 LOAD: R[d] ← imm; `pc`+1.
  - 0000 ADD: R[d] ← R[s]+R[t]; `pc`+1.
  - 0001 SUB: R[d] ← R[s]−R[t]; `pc`+1.
  - 1010 INC: R[d] ← R[d]+1; `pc`+1.
  - 1011 DEC: R[d] ← R[d]−1; `pc`+1.
  - 1111 JMP: `pc` ← addr.
  - 1110 DJNZ: R[d] ← R[d]−1. If the result ≠0, `pc` ← addr; else `pc`+1.
  - 1100 HLT: `pc` unchanged; → HALT.
  - Any other opcode is a NOP: `pc`+1.
- ALU is combinational, 3-bit op, results modulo 256, no flags.
  - 000 A+B, 001 A−B, 010 A&B, 011 A|B.
  - 100 A^B, 101 ~A, 110 A<<1, 111 A>>1 (logical).
  - ADD uses op 000; INC uses op 000 with B=1.
  - SUB uses op 001; DEC and DJNZ use op 001 with B=1.
- Register file: two combinational read ports (s/d and t) plus the debug port; one synchronous write port driven in EXEC.
- The instruction store is synchronous-write and asynchronous-read. Its contents are not cleared by reset.
- `pc` increments wrap 255→0.

## Timing
- Reset values: `pc`=0, `ir`=0, R0–R3=0, state IDLE, `halted`=0.
- Reset wins over every other input, in any state, mid-instruction included. Any partial result is discarded.
- Every instruction takes 2 cycles: FETCH then EXEC.
- The register write and the `pc` update land on the EXEC edge, so the next FETCH sees the new `pc`. A read after write in the next instruction sees the new value.
- `start` to first FETCH edge: 1 cycle.
- HLT: `halted` rises the cycle after the HLT EXEC edge.
- `dbg_data` follows `dbg_addr` combinationally and reflects writes the cycle after the write edge.
- If `imem_we` and `start` are both asserted in the same cycle in IDLE or HALT, the write takes effect and execution starts. A write to address 0 is visible to the first fetch.

## Test plan
- **LOAD/ADD**: LOAD R1,5; LOAD R2,3; ADD R0,R1,R2; HLT → R0=8 via `dbg_data`. `halted`=1 after 8 cycles from the first FETCH.
- **SUB wrap and DEC**: LOAD R1,3; LOAD R2,5; SUB R3,R1,R2; DEC R0 (R0=0) → R3=254, R0=255.
- **INC wrap**: LOAD R1,255; INC R1 → R1=0.
- **JMP**: word 0 = JMP 5; words 1–4 = LOAD R0,9; word 5 = HLT → R0 stays 0; final `pc`=5.
- **DJNZ loop**: LOAD R0,3; LOAD R1,0; [2] INC R1; DJNZ R0,2; HLT → R1=3, R0=0, `halted`=1.
- **Reset and load guard**:
  - Assert `rst` mid-loop → next cycle `pc`=0, all registers 0, `halted`=0, state IDLE.
  - `imem_we` pulses while running are ignored.
  - The program re-runs identically on `start`.
